// File: rtl/dmem_responder.sv
// Data-memory responder: async-read word array, posted-store write buffer with
// load forwarding, and a lower-priority host port for preload and readback.
module dmem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WB_DEPTH = 4,
  localparam int unsigned CNT_W   = $clog2(WB_DEPTH + 1)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [0:DATA_W-1] Wr_Data,
  output logic [0:DATA_W-1] Rd_Data,
  input  logic              DmemEn,
  input  logic              DmemWrEn,
  input  logic              Host_Valid,
  output logic              Host_Ready,
  input  logic              Host_Wr,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [0:DATA_W-1] Host_Wdata,
  output logic              Host_Rvalid,
  output logic [0:DATA_W-1] Host_Rdata,
  output logic [CNT_W-1:0]  Wb_Count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  logic [0:DATA_W-1] mem [DEPTH];

  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [0:DATA_W-1] wb_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] wb_valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              proc_load;
  logic              proc_store;
  logic              wb_full;
  logic              drain;
  logic              host_acc;
  logic [0:DATA_W-1] host_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Walk oldest to youngest so the youngest valid match wins.
  function automatic logic [0:DATA_W-1] lookup(input logic [ADDR_W-1:0] a);
    logic [PTR_W-1:0]  idx;
    logic [0:DATA_W-1] res;
    res = mem[a];
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      idx = PTR_W'((32'(head) + i) % WB_DEPTH);
      if (wb_valid[idx] && (wb_addr[idx] == a)) res = wb_data[idx];
    end
    return res;
  endfunction

  assign proc_load  = DmemEn & ~DmemWrEn;
  assign proc_store = DmemEn & DmemWrEn;
  assign wb_full    = (count == CNT_W'(WB_DEPTH));

  // Array-port arbitration; nothing is granted while reset is asserted.
  always_comb begin
    drain    = 1'b0;
    host_acc = 1'b0;
    if (Reset_n && !proc_load) begin
      if (wb_full)           drain    = 1'b1;
      else if (Host_Valid)   host_acc = 1'b1;
      else if (count != '0)  drain    = 1'b1;
    end
  end

  assign Host_Ready = host_acc;
  assign Wb_Count   = count;
  assign Rd_Data    = lookup(Mem_Addr);
  assign host_rd    = lookup(Host_Addr);

  // Buffer control and host read response.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      wb_valid    <= '0;
      Host_Rvalid <= 1'b0;
      Host_Rdata  <= '0;
    end else begin
      Host_Rvalid <= host_acc & ~Host_Wr;
      if (host_acc && !Host_Wr) Host_Rdata <= host_rd;
      if (host_acc && Host_Wr) begin
        for (int i = 0; i < WB_DEPTH; i++) begin
          if (wb_addr[i] == Host_Addr) wb_valid[i] <= 1'b0;
        end
      end
      if (drain) begin
        wb_valid[head] <= 1'b0;
        head           <= ptr_inc(head);
      end
      if (proc_store) begin
        wb_valid[tail] <= 1'b1;
        tail           <= ptr_inc(tail);
      end
      case ({proc_store, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (proc_store) begin
      wb_addr[tail] <= Mem_Addr;
      wb_data[tail] <= Wr_Data;
    end
  end

  // Killed entries still pop but leave the array untouched.
  always_ff @(posedge Clock) begin
    if (host_acc && Host_Wr)           mem[Host_Addr]     <= Host_Wdata;
    else if (drain && wb_valid[head])  mem[wb_addr[head]] <= wb_data[head];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned CNT_W    = 3;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [0:DATA_W-1] Wr_Data;
  logic [0:DATA_W-1] Rd_Data;
  logic              DmemEn;
  logic              DmemWrEn;
  logic              Host_Valid;
  logic              Host_Ready;
  logic              Host_Wr;
  logic [ADDR_W-1:0] Host_Addr;
  logic [0:DATA_W-1] Host_Wdata;
  logic              Host_Rvalid;
  logic [0:DATA_W-1] Host_Rdata;
  logic [CNT_W-1:0]  Wb_Count;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Mem_Addr(Mem_Addr), .Wr_Data(Wr_Data),
    .Rd_Data(Rd_Data), .DmemEn(DmemEn), .DmemWrEn(DmemWrEn),
    .Host_Valid(Host_Valid), .Host_Ready(Host_Ready), .Host_Wr(Host_Wr),
    .Host_Addr(Host_Addr), .Host_Wdata(Host_Wdata), .Host_Rvalid(Host_Rvalid),
    .Host_Rdata(Host_Rdata), .Wb_Count(Wb_Count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    Host_Valid = 1'b1; Host_Wr = 1'b1; Host_Addr = a; Host_Wdata = d;
    #1 check("hw_ready", 64'(Host_Ready), 64'd1);
    tick();
    Host_Valid = 1'b0; Host_Wr = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [ADDR_W-1:0] a, input logic [63:0] exp);
    Host_Valid = 1'b1; Host_Wr = 1'b0; Host_Addr = a;
    #1 check({tag, "_ready"}, 64'(Host_Ready), 64'd1);
    tick();
    Host_Valid = 1'b0;
    check({tag, "_rvalid"}, 64'(Host_Rvalid), 64'd1);
    check({tag, "_rdata"}, Host_Rdata, exp);
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    DmemEn = 1'b1; DmemWrEn = 1'b1; Mem_Addr = a; Wr_Data = d;
    tick();
    DmemEn = 1'b0; DmemWrEn = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; DmemEn = 1'b0; DmemWrEn = 1'b0; Mem_Addr = '0; Wr_Data = '0;
    Host_Valid = 1'b1; Host_Wr = 1'b0; Host_Addr = '0; Host_Wdata = '0;
    #12;
    check("rst_count", 64'(Wb_Count), 64'd0);
    check("rst_rvalid", 64'(Host_Rvalid), 64'd0);
    check("rst_rdata", Host_Rdata, 64'd0);
    check("rst_ready", 64'(Host_Ready), 64'd0);
    Host_Valid = 1'b0;
    @(negedge Clock) Reset_n = 1'b1;
    tick();

    // Preload and readback
    host_write(8'h10, 64'hDEAD_BEEF_0000_0001);
    host_read("t1", 8'h10, 64'hDEAD_BEEF_0000_0001);
    tick();
    check("t1_rvalid_drop", 64'(Host_Rvalid), 64'd0);
    check("t1_rdata_hold", Host_Rdata, 64'hDEAD_BEEF_0000_0001);
    for (int i = 0; i < 3; i++) host_write(ADDR_W'(32'h50 + i), 64'hF0);

    // Forwarding with drains blocked by a held host read
    Host_Valid = 1'b1; Host_Wr = 1'b0; Host_Addr = 8'h10;
    store(8'h05, 64'h11);
    store(8'h05, 64'h22);
    Host_Valid = 1'b0;
    check("t2_count", 64'(Wb_Count), 64'd2);
    DmemEn = 1'b1; DmemWrEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Mem_Addr = (i % 2 == 0) ? 8'h05 : 8'h10;
      #1 check("t4_rd", Rd_Data, (i % 2 == 0) ? 64'h22 : 64'hDEAD_BEEF_0000_0001);
      tick();
      check("t4_count_hold", 64'(Wb_Count), 64'd2);
    end
    DmemEn = 1'b0;
    tick();
    check("t4_drain1", 64'(Wb_Count), 64'd1);
    tick();
    check("t4_drain0", 64'(Wb_Count), 64'd0);
    host_read("t2", 8'h05, 64'h22);

    // Full buffer with host held valid
    Host_Valid = 1'b1; Host_Wr = 1'b0; Host_Addr = 8'h10;
    for (int i = 0; i < 5; i++) begin
      DmemEn = 1'b1; DmemWrEn = 1'b1;
      Mem_Addr = ADDR_W'(32'h40 + i); Wr_Data = 64'(256 + i);
      #1 check("t3_ready", 64'(Host_Ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
      check("t3_count", 64'(Wb_Count), (i < 4) ? 64'(i + 1) : 64'd4);
    end
    DmemEn = 1'b0; DmemWrEn = 1'b0;
    #1 check("t3_full_ready", 64'(Host_Ready), 64'd0);
    tick();
    check("t3_count3", 64'(Wb_Count), 64'd3);
    #1 check("t3_ready_again", 64'(Host_Ready), 64'd1);
    tick();
    Host_Valid = 1'b0;
    for (int i = 0; i < 10 && Wb_Count != '0; i++) tick();
    check("t3_empty", 64'(Wb_Count), 64'd0);
    host_read("t3_old", 8'h40, 64'h100);
    host_read("t3_new", 8'h44, 64'h104);

    // Host write kills a buffered store
    store(8'h30, 64'hAA);
    check("t5_count1", 64'(Wb_Count), 64'd1);
    host_write(8'h30, 64'hBB);
    check("t5_count_kept", 64'(Wb_Count), 64'd1);
    DmemEn = 1'b1; DmemWrEn = 1'b0; Mem_Addr = 8'h30;
    #1 check("t5_fwd_killed", Rd_Data, 64'hBB);
    tick();
    DmemEn = 1'b0;
    tick();
    check("t5_count0", 64'(Wb_Count), 64'd0);
    host_read("t5", 8'h30, 64'hBB);

    // Asynchronous reset with stores still buffered
    Host_Valid = 1'b1; Host_Wr = 1'b0; Host_Addr = 8'h10;
    for (int i = 0; i < 3; i++) store(ADDR_W'(32'h50 + i), 64'(i + 1));
    Host_Valid = 1'b0;
    check("t6_count3", 64'(Wb_Count), 64'd3);
    check("t6_rvalid_pre", 64'(Host_Rvalid), 64'd1);
    #3 Reset_n = 1'b0;
    #1;
    check("t6_count_rst", 64'(Wb_Count), 64'd0);
    check("t6_rvalid_rst", 64'(Host_Rvalid), 64'd0);
    check("t6_rdata_rst", Host_Rdata, 64'd0);
    @(negedge Clock) Reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) host_read("t6_arr", ADDR_W'(32'h50 + i), 64'hF0);
    check("t6_count_end", 64'(Wb_Count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
